// File: rtl/hs_cdc_src.sv
// hs_cdc_src: source-domain end of a two-phase (toggle) req/ack crossing.
// A word accepted on the valid/ready side is parked on xfer_data_o, then one
// cycle later xfer_req_o toggles. The block waits until the synchronized
// acknowledge level matches the request level before accepting another word.
// A sticky timeout flags an acknowledge that is overdue, but the transfer is
// never aborted: a late acknowledge still completes it normally.
module hs_cdc_src #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,    // legal range 2..4
  parameter int TIMEOUT_CYC = 1024  // legal range >= 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] xfer_data_o,
  output logic              xfer_req_o,
  input  logic              xfer_ack_i,
  output logic              done_o,
  output logic              timeout_o,
  input  logic              clr_err_i,
  output logic [15:0]       xfer_cnt_o
);

  // Wait counter must be able to hold TIMEOUT_CYC itself (saturation value).
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                req_reg, req_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                timeout_reg, timeout_next;
  logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
  logic [15:0]         xfer_cnt_reg, xfer_cnt_next;

  logic                ack_s;
  logic                ack_match;
  logic                timeout_set;

  // ------------------------------------------------------------------------
  // Acknowledge synchronizer. xfer_ack_i is asynchronous to clk_i; it is only
  // ever read by the first stage below, and everything else uses ack_s.
  // ------------------------------------------------------------------------
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic stage_reg;
    if (gi == 0) begin : g_first
      // First stage samples the raw asynchronous acknowledge level.
      always_ff @(posedge clk_i) begin
        if (rst_i) stage_reg <= 1'b0;
        else       stage_reg <= xfer_ack_i;
      end
    end else begin : g_next
      // Later stages only resolve metastability of the previous stage.
      always_ff @(posedge clk_i) begin
        if (rst_i) stage_reg <= 1'b0;
        else       stage_reg <= g_sync[gi-1].stage_reg;
      end
    end
  end

  assign ack_s     = g_sync[SYNC_STAGES-1].stage_reg;
  // Two-phase protocol: the destination has consumed the word once its ack
  // level has caught up with our request level.
  assign ack_match = (ack_s == req_reg);

  // ------------------------------------------------------------------------
  // State and datapath registers.
  // ------------------------------------------------------------------------
  // All registers clear on reset, which also drops any word in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      data_reg     <= '0;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      wait_cnt_reg <= '0;
      xfer_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      req_reg      <= req_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
      wait_cnt_reg <= wait_cnt_next;
      xfer_cnt_reg <= xfer_cnt_next;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic: IDLE -> SETUP on accept, SETUP lasts one cycle so the
  // data bus settles before the request toggles, WAIT until ack catches up.
  // ------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (in_valid_i) state_next = ST_SETUP;
      ST_SETUP: state_next = ST_WAIT;
      ST_WAIT:  if (ack_match) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Timeout fires only on the cycle the counter reaches its limit, so a
  // saturated counter does not keep re-asserting after software clears it.
  assign timeout_set = (state_reg == ST_WAIT) && !ack_match && (wait_cnt_reg == WAIT_LAST);

  // ------------------------------------------------------------------------
  // Output / datapath next values, all registered.
  // ------------------------------------------------------------------------
  always_comb begin
    data_next     = data_reg;
    req_next      = req_reg;
    done_next     = 1'b0;
    wait_cnt_next = wait_cnt_reg;
    xfer_cnt_next = xfer_cnt_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (in_valid_i) data_next = in_data_i;
      end
      ST_SETUP: begin
        req_next      = ~req_reg;
        wait_cnt_next = '0;
      end
      ST_WAIT: begin
        if (ack_match) begin
          done_next     = 1'b1;
          xfer_cnt_next = xfer_cnt_reg + 16'd1;   // wraps silently at 2^16
        end else if (wait_cnt_reg != WAIT_MAX) begin
          wait_cnt_next = wait_cnt_reg + WAIT_ONE;
        end
      end
      default: begin
        data_next = data_reg;
      end
    endcase

    // Set has priority over clear so a timeout coinciding with a clear is
    // not lost.
    if (timeout_set)    timeout_next = 1'b1;
    else if (clr_err_i) timeout_next = 1'b0;
    else                timeout_next = timeout_reg;

    // Ready is registered: it reflects the state we are about to enter.
    busy_next = (state_next != ST_IDLE);
  end

  assign in_ready_o  = ~busy_reg;
  assign xfer_data_o = data_reg;
  assign xfer_req_o  = req_reg;
  assign done_o      = done_reg;
  assign timeout_o   = timeout_reg;
  assign xfer_cnt_o  = xfer_cnt_reg;

endmodule
